// File: rtl/loader_pkg.sv
// +---------------------------------------------------------------------------+
// | loader_pkg : kind codes, MIPS opcode/funct values and loader FSM states    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

package loader_pkg;

  typedef enum logic [4:0] {
    K_ADD  = 5'd0,
    K_SUB  = 5'd1,
    K_AND  = 5'd2,
    K_OR   = 5'd3,
    K_SLT  = 5'd4,
    K_SLL  = 5'd5,
    K_SRL  = 5'd6,
    K_SRA  = 5'd7,
    K_JR   = 5'd8,
    K_ADDI = 5'd9,
    K_ANDI = 5'd10,
    K_ORI  = 5'd11,
    K_SLTI = 5'd12,
    K_LW   = 5'd13,
    K_SW   = 5'd14,
    K_BEQ  = 5'd15,
    K_BNE  = 5'd16,
    K_J    = 5'd17,
    K_JAL  = 5'd18,
    K_NOP  = 5'd19
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_encoder.sv
// +---------------------------------------------------------------------------+
// | instr_encoder : kind + register/immediate fields -> 32-bit MIPS word       |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module instr_encoder
  import loader_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Each arm builds only the fields its format uses; everything else is zero.
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (kind)
      K_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      K_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      K_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      K_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      K_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      K_SLL:  word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      K_SRL:  word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      K_SRA:  word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRA};
      K_JR:   word = {OP_RTYPE, rs, 15'd0, FN_JR};
      K_ADDI: word = {OP_ADDI, rs, rt, imm};
      K_ANDI: word = {OP_ANDI, rs, rt, imm};
      K_ORI:  word = {OP_ORI,  rs, rt, imm};
      K_SLTI: word = {OP_SLTI, rs, rt, imm};
      K_LW:   word = {OP_LW,   rs, rt, imm};
      K_SW:   word = {OP_SW,   rs, rt, imm};
      K_BEQ:  word = {OP_BEQ,  rs, rt, imm};
      K_BNE:  word = {OP_BNE,  rs, rt, imm};
      K_J:    word = {OP_J,   target};
      K_JAL:  word = {OP_JAL, target};
      K_NOP:  word = 32'h0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader_encoder.sv
// +---------------------------------------------------------------------------+
// | imem_loader_encoder : encodes instructions and streams them into IMEM      |
// | Optional: LOADER_CHECKSUM_EN adds an XOR checksum of written words. Rev 1.0|
// +---------------------------------------------------------------------------+
`default_nettype none

module imem_loader_encoder
  import loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    kind,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]   csum
`endif
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   LAST_CNT = (AW + 1)'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;
  logic          full_q, full_d;
  logic          imem_we_q, imem_we_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;

  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          accept;

  instr_encoder u_enc (
    .kind    (kind),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .imm     (imm),
    .target  (target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    err_d        = err_q;
    imem_we_d    = 1'b0;
    imem_wdata_d = imem_wdata_q;
    if (start) begin
      // start overrides any handshake or finish in the same cycle
      state_d = LOAD;
      ptr_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (accept) begin
        if (enc_illegal) begin
          err_d = 1'b1;
        end else begin
          imem_we_d    = 1'b1;
          imem_wdata_d = enc_word;
          ptr_d        = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
          count_d      = count_q + 1'b1;
          if (count_q == LAST_CNT) state_d = FULL;
        end
      end
      if (finish && (state_q != IDLE)) state_d = IDLE;
    end
    // Between writes the address port shows the next write pointer.
    imem_addr_d = imem_we_d ? ptr_q : ptr_d;
    in_ready_d  = (state_d == LOAD);
    full_d      = (state_d == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      full_q       <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      full_q       <= full_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start)          csum_d = 32'h0;
    else if (imem_we_q) csum_d = csum_q ^ imem_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) csum_q <= 32'h0;
    else        csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader_encoder.sv
// +---------------------------------------------------------------------------+
// | tb_imem_loader_encoder : directed + random bench with a behavioural model  |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader_encoder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    kind = 5'd0;
  logic [4:0]    rs = 5'd0;
  logic [4:0]    rt = 5'd0;
  logic [4:0]    rd = 5'd0;
  logic [4:0]    shamt = 5'd0;
  logic [15:0]   imm = 16'd0;
  logic [25:0]   target = 26'd0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   csum;
`endif

  imem_loader_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .kind       (kind),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .imm        (imm),
    .target     (target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err)
`ifdef LOADER_CHECKSUM_EN
    ,
    .csum       (csum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 = idle, 1 = loading, 2 = full
  int          m_mode = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_err = 0;
  bit          e_we = 0;
  int          e_addr = 0;
  logic [31:0] e_wd = 32'h0;
  logic [31:0] e_csum = 32'h0;

  function automatic logic [31:0] ref_enc(int k, logic [31:0] f_rs, logic [31:0] f_rt,
                                          logic [31:0] f_rd, logic [31:0] f_sh,
                                          logic [31:0] f_imm, logic [31:0] f_tgt);
    logic [31:0] fn [0:8];
    logic [31:0] op [0:9];
    fn = '{32'd32, 32'd34, 32'd36, 32'd37, 32'd42, 32'd0, 32'd2, 32'd3, 32'd8};
    op = '{32'd8, 32'd12, 32'd13, 32'd10, 32'd35, 32'd43, 32'd4, 32'd5, 32'd2, 32'd3};
    if (k <= 4)  return (f_rs << 21) | (f_rt << 16) | (f_rd << 11) | fn[k];
    if (k <= 7)  return (f_rt << 16) | (f_rd << 11) | (f_sh << 6) | fn[k];
    if (k == 8)  return (f_rs << 21) | 32'd8;
    if (k <= 16) return (op[k-9] << 26) | (f_rs << 21) | (f_rt << 16) | f_imm;
    if (k <= 18) return (op[k-9] << 26) | f_tgt;
    return 32'h0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model using the inputs the DUT is about to sample.
  task automatic model_step();
    int prev_mode;
    bool_t_dummy: begin end
    if (!rst_n) begin
      m_mode = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
      e_we = 0; e_addr = 0; e_wd = 32'h0; e_csum = 32'h0;
      return;
    end
    if (start) e_csum = 32'h0;
    else if (e_we) e_csum = e_csum ^ e_wd;
    prev_mode = m_mode;
    e_we = 0;
    if (start) begin
      m_mode = 1; m_ptr = 0; m_cnt = 0; m_err = 0;
    end else begin
      if (in_valid && prev_mode == 1) begin
        if (kind >= 20) m_err = 1;
        else begin
          e_we   = 1;
          e_wd   = ref_enc(int'(kind), 32'(rs), 32'(rt), 32'(rd), 32'(shamt),
                           32'(imm), 32'(target));
          e_addr = m_ptr;
          m_ptr  = (m_ptr + 1) % DEPTH;
          m_cnt  = m_cnt + 1;
          if (m_cnt == DEPTH) m_mode = 2;
        end
      end
      if (finish && prev_mode != 0) m_mode = 0;
    end
    if (!e_we) e_addr = m_ptr;
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(m_mode == 1));
    chk("imem_we", 32'(imem_we), 32'(e_we));
    chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    chk("imem_wdata", imem_wdata, e_wd);
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_mode == 2));
    chk("err", 32'(err), 32'(m_err));
`ifdef LOADER_CHECKSUM_EN
    chk("csum", csum, e_csum);
`endif
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_instr(int k, int a, int b, int c, int s, int i, int t);
    kind = 5'(k); rs = 5'(a); rt = 5'(b); rd = 5'(c); shamt = 5'(s);
    imm = 16'(i); target = 26'(t);
  endtask

  initial begin
    // Pin the model encoder to hand-computed words.
    chk("model_addi", ref_enc(9, 0, 8, 0, 0, 5, 0), 32'h20080005);
    chk("model_add", ref_enc(0, 1, 2, 3, 0, 0, 0), 32'h00221820);
    chk("model_sll", ref_enc(5, 7, 1, 2, 4, 0, 0), 32'h00011100);
    chk("model_jal", ref_enc(18, 0, 0, 0, 0, 0, 32'h40), 32'h0C000040);
    chk("model_jr", ref_enc(8, 31, 0, 0, 0, 0, 0), 32'h03E00008);

    // Reset
    rst_n = 1'b0;
    cyc(); cyc();
    chk("reset_we", 32'(imem_we), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    cyc();

    // First write
    start = 1'b1; cyc(); start = 1'b0;
    set_instr(9, 0, 8, 0, 0, 5, 0); in_valid = 1'b1; cyc(); in_valid = 1'b0;
    chk("addi_we", 32'(imem_we), 32'd1);
    chk("addi_wdata", imem_wdata, 32'h20080005);
    chk("addi_addr", 32'(imem_addr), 32'd0);
    chk("addi_count", 32'(count), 32'd1);
    cyc();

    // Back-to-back, shift with rs masked, JAL
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1;
    set_instr(0, 1, 2, 3, 0, 16'hFFFF, 26'h3FFFFFF); cyc();
    chk("b2b_add", imem_wdata, 32'h00221820);
    chk("b2b_add_addr", 32'(imem_addr), 32'd0);
    set_instr(5, 7, 1, 2, 4, 16'hFFFF, 0); cyc();
    chk("b2b_sll", imem_wdata, 32'h00011100);
    chk("b2b_sll_addr", 32'(imem_addr), 32'd1);
    set_instr(18, 31, 31, 31, 31, 16'hFFFF, 32'h40); cyc();
    chk("b2b_jal", imem_wdata, 32'h0C000040);
    chk("b2b_jal_addr", 32'(imem_addr), 32'd2);
    in_valid = 1'b0; cyc();

    // Fill with NOPs at continuous valid
    start = 1'b1; cyc(); start = 1'b0;
    set_instr(19, 3, 3, 3, 3, 3, 3); in_valid = 1'b1;
    repeat (DEPTH) cyc();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'(DEPTH));
    chk("fill_last_addr", 32'(imem_addr), 32'(DEPTH - 1));
    cyc(); cyc();
    chk("fill_no_extra", 32'(imem_we), 32'd0);
    chk("fill_ptr_wrap", 32'(imem_addr), 32'd0);
    in_valid = 1'b0;
    finish = 1'b1; cyc(); finish = 1'b0;
    chk("finish_idle", 32'(full), 32'd0);

    // Illegal kind
    start = 1'b1; cyc(); start = 1'b0;
    set_instr(0, 1, 2, 3, 0, 0, 0); in_valid = 1'b1; cyc();
    set_instr(25, 1, 2, 3, 0, 0, 0); cyc();
    chk("ill_we", 32'(imem_we), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    in_valid = 1'b0; cyc(); cyc();
    chk("ill_sticky", 32'(err), 32'd1);
    set_instr(9, 0, 8, 0, 0, 5, 0); in_valid = 1'b1; cyc(); in_valid = 1'b0;
    chk("ill_next_addr", 32'(imem_addr), 32'd1);
    chk("ill_next_wdata", imem_wdata, 32'h20080005);
    start = 1'b1; cyc(); start = 1'b0;
    chk("ill_clear_err", 32'(err), 32'd0);
    chk("ill_clear_cnt", 32'(count), 32'd0);

    // Reset during LOAD with valid high
    set_instr(0, 1, 2, 3, 0, 0, 0); in_valid = 1'b1; cyc();
    rst_n = 1'b0; cyc();
    chk("rst_mid_we", 32'(imem_we), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; cyc();

    // start and finish together
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1; set_instr(19, 0, 0, 0, 0, 0, 0); cyc(); cyc(); in_valid = 1'b0;
    start = 1'b1; finish = 1'b1; cyc(); start = 1'b0; finish = 1'b0;
    chk("sf_ready", 32'(in_ready), 32'd1);
    chk("sf_count", 32'(count), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1;
    set_instr(9, 0, 8, 0, 0, 5, 0); cyc();
    set_instr(0, 1, 2, 3, 0, 0, 0); cyc();
    in_valid = 1'b0; cyc();
    chk("csum_lit", csum, 32'h202A1825);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) kind = 5'($urandom_range(20, 31));
      else kind = 5'($urandom_range(0, 19));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      shamt = 5'($urandom); imm = 16'($urandom); target = 26'($urandom);
      start  = ($urandom_range(0, 149) == 0);
      finish = ($urandom_range(0, 199) == 0);
      rst_n  = ($urandom_range(0, 499) != 0);
      cyc();
    end
    start = 1'b0; finish = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
